dsc_mul_seq: RTL

Operand sequencer and result capture stage wrapped around the serial early-shutoff deterministic stochastic multiplier (dsc_mul).
- Accepts binary operand pairs over a valid/ready handshake.
- Clears the multiplier, then enables it for one stochastic run.
- Ends the run on the multiplier's early-shutoff flag or on a watchdog limit.
- Captures the binary product and presents it on a valid/ready result port.
Sits between the operand source and the multiplier.

---
 rtl/dsc_pkg.sv | 22 ++
 rtl/dsc_run_ctr.sv | 42 ++++
 rtl/dsc_mul_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dsc_pkg.sv
// Shared constants, state encoding and watchdog derivation for the dsc_mul sequencer.
package dsc_pkg;

  localparam int SNG_WIDTH  = 4;
  localparam int NUM_INPUTS = 2;

  // The watchdog allows one full stochastic period: 2**(NI*W) clocks.
  function automatic int max_cyc(input int w, input int ni);
    return 1 << (w * ni);
  endfunction

  localparam int MAX_CYC = max_cyc(SNG_WIDTH, NUM_INPUTS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/dsc_run_ctr.sv
// Run-length up-counter with synchronous clear, enable and watchdog terminal-count flag.
module dsc_run_ctr #(
  parameter int CW      = 9,
  parameter int MAX_CYC = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW:0] LIMIT = (CW+1)'(MAX_CYC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW:0]   cnt_inc;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count fires in the cycle whose run length would reach the limit.
  assign cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);
  assign tc      = (cnt_inc == LIMIT);
  assign cnt     = cnt_q;

endmodule

// File: rtl/dsc_mul_seq.sv
// Operand sequencer and result capture around the serial early-shutoff DSC multiplier.
// Optional macro DSC_SEQ_ZERO_BYPASS_EN: zero operands skip the run and complete at once.
module dsc_mul_seq
  import dsc_pkg::*;
#(
  parameter int W       = SNG_WIDTH,
  parameter int NI      = NUM_INPUTS,
  parameter int MAX_CYC = max_cyc(W, NI)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  output logic [W-1:0]    mul_a,
  output logic [W-1:0]    mul_b,
  output logic            mul_en,
  output logic            mul_clr,
  input  logic            mul_ov,
  input  logic [NI*W-1:0] mul_z,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [NI*W-1:0] res_z,
  output logic [NI*W:0]   res_cyc,
  output logic            res_timeout
);

  localparam int PW = NI * W;
  localparam int CW = PW + 1;

  seq_state_e    state_q, state_d;
  logic [W-1:0]  mul_a_q, mul_a_d;
  logic [W-1:0]  mul_b_q, mul_b_d;
  logic [PW-1:0] res_z_q, res_z_d;
  logic [CW-1:0] res_cyc_q, res_cyc_d;
  logic          res_timeout_q, res_timeout_d;

  logic          ctr_clr;
  logic          ctr_en;
  logic [CW-1:0] run_cnt;
  logic          run_tc;
  logic          ov_exit;

  dsc_run_ctr #(
    .CW      (CW),
    .MAX_CYC (MAX_CYC)
  ) u_run_ctr (
    .clk (clk),
    .rst (rst),
    .clr (ctr_clr),
    .en  (ctr_en),
    .cnt (run_cnt),
    .tc  (run_tc)
  );

  always_comb begin
    state_d       = state_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    res_z_d       = res_z_q;
    res_cyc_d     = res_cyc_q;
    res_timeout_d = res_timeout_q;
    ctr_clr       = 1'b0;
    ctr_en        = 1'b0;
    ov_exit       = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mul_a_d = in_a;
          mul_b_d = in_b;
`ifdef DSC_SEQ_ZERO_BYPASS_EN
          if ((in_a == '0) || (in_b == '0)) begin
            state_d       = DONE;
            res_z_d       = '0;
            res_cyc_d     = '0;
            res_timeout_d = 1'b0;
          end else begin
            state_d = CLEAR;
          end
`else
          state_d = CLEAR;
`endif
        end
      end
      CLEAR: begin
        ctr_clr = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        ctr_en = 1'b1;
        // The first RUN cycle masks the flag while the multiplier settles.
        ov_exit = mul_ov && (run_cnt != '0);
        if (ov_exit || run_tc) begin
          res_cyc_d     = run_cnt + CW'(1);
          res_timeout_d = !ov_exit;
          state_d       = DRAIN;
        end
      end
      DRAIN: begin
        res_z_d = mul_z;
        state_d = DONE;
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      res_z_q       <= '0;
      res_cyc_q     <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      res_z_q       <= res_z_d;
      res_cyc_q     <= res_cyc_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  // Decoding straight from the state flop lets reset drop mul_en without waiting for a clock.
  assign in_ready    = (state_q == IDLE);
  assign mul_clr     = (state_q == CLEAR);
  assign mul_en      = (state_q == RUN);
  assign res_valid   = (state_q == DONE);
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign res_z       = res_z_q;
  assign res_cyc     = res_cyc_q;
  assign res_timeout = res_timeout_q;

endmodule
